sram_mem_stage: RTL and testbench

Memory stage of the ARM pipeline, placed between the EXE stage register and the MEM stage register. It performs 32-bit LDR/STR data accesses to an external 16-bit-wide SRAM as two halfword transactions with programmable wait states. While an access is in progress it drops `ready`, which the pipeline uses as its freeze. Non-memory instructions pass through combinationally with no stall.

---
 rtl/sram_mem_stage.sv | 158 +++++++++++++++
 tb/tb_sram_mem_stage.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_stage.sv
// sram_mem_stage: ARM MEM stage doing 32-bit LDR/STR as two halfword phases on a 16-bit SRAM.
// Latency: non-memory ops 0 cycles; memory ops stall 2*WAIT_CYCLES+3 cycles, result in the DONE cycle.
// Backpressure: ready=0 freezes the whole pipeline; upstream holds all inputs stable meanwhile.
module sram_mem_stage #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_read_en_in,
    input  logic        mem_write_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_Rm_in,
    input  logic [3:0]  dest_in,
    output logic        wb_en_out,
    output logic        mem_read_en_out,
    output logic [31:0] alu_res_out,
    output logic [3:0]  dest_out,
    output logic [31:0] mem_data_out,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        is_write;
    logic        is_write_nxt;
    logic [31:0] data;
    logic [31:0] data_nxt;
    logic [31:0] mem_data_q;
    logic [31:0] mem_data_nxt;

    logic        request;
    logic        phase_last;
    logic [31:0] offset;
    logic [16:0] word_addr;
    logic        unused_offset_bits;

    assign request    = mem_read_en_in | mem_write_en_in;
    assign offset     = alu_res_in - 32'(BASE_ADDR);
    assign word_addr  = offset[18:2];
    assign phase_last = (cnt == CNT_LAST);

    // Byte offset and bits above the 17-bit word index wrap away silently.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    assign wb_en_out       = wb_en_in & ready;
    assign mem_read_en_out = mem_read_en_in & ready;
    assign alu_res_out     = alu_res_in;
    assign dest_out        = dest_in;
    assign mem_data_out    = mem_data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            is_write   <= 1'b0;
            data       <= 32'd0;
            mem_data_q <= 32'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            is_write   <= is_write_nxt;
            data       <= data_nxt;
            mem_data_q <= mem_data_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        is_write_nxt = is_write;
        data_nxt     = data;
        mem_data_nxt = mem_data_q;
        ready        = 1'b0;
        sram_addr    = 18'd0;
        sram_dq_out  = 16'd0;
        sram_dq_oe   = 1'b0;
        sram_we_n    = 1'b1;

        case (state)
            ST_IDLE: begin
                ready = !request;
                if (request) begin
                    // A simultaneous read+write request is treated as a write.
                    is_write_nxt = mem_write_en_in;
                    cnt_nxt      = 4'd0;
                    state_nxt    = ST_LO;
                end
            end

            ST_LO: begin
                sram_addr = {word_addr, 1'b0};
                if (is_write) begin
                    sram_dq_out = val_Rm_in[15:0];
                    sram_dq_oe  = 1'b1;
                    // Strobe released in the final cycle so address/data are held past it.
                    sram_we_n   = (cnt >= CNT_LAST);
                end
                if (phase_last) begin
                    if (!is_write) begin
                        data_nxt[15:0] = sram_dq_in;
                    end
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_HI;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end

            ST_HI: begin
                sram_addr = {word_addr, 1'b1};
                if (is_write) begin
                    sram_dq_out = val_Rm_in[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = (cnt >= CNT_LAST);
                end
                if (phase_last) begin
                    if (!is_write) begin
                        data_nxt[31:16] = sram_dq_in;
                        mem_data_nxt    = {sram_dq_in, data[15:0]};
                    end
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end

            ST_DONE: begin
                // Pipeline advances on this edge, so the held request is consumed.
                ready     = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: two instances (WAIT_CYCLES 1 and 3) sharing inputs and one halfword SRAM model,
// checked against a word-level reference memory.
module tb_sram_mem_stage;
    localparam int BASE = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        wb_en_in;
    logic        mem_read_en_in;
    logic        mem_write_en_in;
    logic [31:0] alu_res_in;
    logic [31:0] val_Rm_in;
    logic [3:0]  dest_in;

    logic        rst_n      [2];
    logic        wb_out_o   [2];
    logic        rd_out_o   [2];
    logic [31:0] alu_out_o  [2];
    logic [3:0]  dest_out_o [2];
    logic [31:0] mdo_o      [2];
    logic        ready_o    [2];
    logic [17:0] addr_o     [2];
    logic [15:0] dq_out_o   [2];
    logic        oe_o       [2];
    logic [15:0] dq_in_o    [2];
    logic        we_n_o     [2];

    sram_mem_stage #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst_n[0]),
        .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
        .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in), .dest_in(dest_in),
        .wb_en_out(wb_out_o[0]), .mem_read_en_out(rd_out_o[0]), .alu_res_out(alu_out_o[0]),
        .dest_out(dest_out_o[0]), .mem_data_out(mdo_o[0]), .ready(ready_o[0]),
        .sram_addr(addr_o[0]), .sram_dq_out(dq_out_o[0]), .sram_dq_oe(oe_o[0]),
        .sram_dq_in(dq_in_o[0]), .sram_we_n(we_n_o[0])
    );

    sram_mem_stage #(.BASE_ADDR(BASE), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst_n[1]),
        .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
        .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in), .dest_in(dest_in),
        .wb_en_out(wb_out_o[1]), .mem_read_en_out(rd_out_o[1]), .alu_res_out(alu_out_o[1]),
        .dest_out(dest_out_o[1]), .mem_data_out(mdo_o[1]), .ready(ready_o[1]),
        .sram_addr(addr_o[1]), .sram_dq_out(dq_out_o[1]), .sram_dq_oe(oe_o[1]),
        .sram_dq_in(dq_in_o[1]), .sram_we_n(we_n_o[1])
    );

    int errors = 0;
    int checks = 0;
    int sel = 0;
    int commits = 0;
    logic [31:0] exp_mdo [2];

    // Halfword SRAM: a write commits when the strobe rises with address and data still driven.
    logic [15:0] sram [int unsigned];
    logic        prev_we_low [2];
    logic [17:0] prev_addr   [2];
    logic [15:0] prev_dat    [2];

    function automatic logic [15:0] sram_rd(input logic [17:0] a);
        if (sram.exists(int'(a))) return sram[int'(a)];
        return 16'h0;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (prev_we_low[k] && we_n_o[k] && oe_o[k] && addr_o[k] == prev_addr[k]) begin
                sram[int'(prev_addr[k])] = prev_dat[k];
                commits++;
            end
            prev_we_low[k] = !we_n_o[k] && oe_o[k];
            prev_addr[k]   = addr_o[k];
            prev_dat[k]    = dq_out_o[k];
            dq_in_o[k]     = sram_rd(addr_o[k]);
        end
    end

    // Word-level reference memory.
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_rd(input logic [16:0] w);
        if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
        return 32'h0;
    endfunction

    function automatic logic [16:0] word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - 32'(BASE)) >> 2;
        return off[16:0];
    endfunction

    task automatic set_idle();
        wb_en_in = 1'b0; mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
    endtask

    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata);
        int W;
        int stall;
        bit done;
        bit bad;
        int c0;
        logic [16:0] w;
        logic [31:0] exp_rd;
        logic [17:0] ea;
        bit in_lo, in_hi, ewl, eoe;
        W = (sel == 0) ? 1 : 3;
        stall = 0; done = 0; bad = 0;
        c0 = commits;
        w = word_of(addr);
        exp_rd = ref_rd(w);
        @(negedge clk);
        wb_en_in = rd & !wr; mem_read_en_in = rd; mem_write_en_in = wr;
        alu_res_in = addr; val_Rm_in = wdata; dest_in = 4'($urandom);
        for (int i = 0; i < 64 && !done; i++) begin
            #1;
            if (ready_o[sel]) begin
                done = 1;
            end else begin
                in_lo = (i >= 1 && i <= W + 1);
                in_hi = (i >= W + 2 && i <= 2 * W + 2);
                ea    = in_lo ? {w, 1'b0} : (in_hi ? {w, 1'b1} : 18'h0);
                eoe   = wr && (in_lo || in_hi);
                ewl   = wr && ((i >= 1 && i <= W) || (i >= W + 2 && i <= 2 * W + 1));
                if (addr_o[sel] !== ea || oe_o[sel] !== eoe || we_n_o[sel] !== !ewl ||
                    wb_out_o[sel] !== 1'b0 || rd_out_o[sel] !== 1'b0) bad = 1;
                if (eoe && dq_out_o[sel] !== (in_lo ? wdata[15:0] : wdata[31:16])) bad = 1;
                stall++;
                @(negedge clk);
            end
        end
        checks++;
        if (!done || stall != 2 * W + 3) begin
            errors++;
            $display("FAIL stall_len addr=%h wr=%0d: ready low for %0d cycles (done=%0d), want %0d", addr, wr, stall, done, 2 * W + 3);
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL sram_waveform addr=%h wr=%0d: bus/strobe/enables deviated from expected phase pattern", addr, wr);
        end
        if (done) begin
            checks++;
            if (wb_out_o[sel] !== (rd & !wr) || rd_out_o[sel] !== rd || alu_out_o[sel] !== addr || dest_out_o[sel] !== dest_in) begin
                errors++;
                $display("FAIL done_ctrl: wb=%b rd=%b alu=%h dest=%h, want wb=%b rd=%b alu=%h dest=%h",
                         wb_out_o[sel], rd_out_o[sel], alu_out_o[sel], dest_out_o[sel], rd & !wr, rd, addr, dest_in);
            end
            checks++;
            if (we_n_o[sel] !== 1'b1 || oe_o[sel] !== 1'b0 || addr_o[sel] !== 18'h0) begin
                errors++;
                $display("FAIL done_idle_bus: we_n=%b oe=%b addr=%h, want 1 0 0", we_n_o[sel], oe_o[sel], addr_o[sel]);
            end
            if (rd && !wr) exp_mdo[sel] = exp_rd;
            checks++;
            if (mdo_o[sel] !== exp_mdo[sel]) begin
                errors++;
                $display("FAIL mem_data_out addr=%h wr=%0d: got %h want %h", addr, wr, mdo_o[sel], exp_mdo[sel]);
            end
        end
        if (wr) ref_mem[int'(w)] = wdata;
        checks++;
        if (commits - c0 != (wr ? 2 : 0)) begin
            errors++;
            $display("FAIL sram_commits addr=%h: got %0d halfword writes, want %0d", addr, commits - c0, wr ? 2 : 0);
        end
    endtask

    task automatic test_reset();
        int n;
        sel = 0;
        wb_en_in = 1'b0; mem_read_en_in = 1'b0; mem_write_en_in = 1'b1;
        alu_res_in = 32'(BASE) + 32'h100; val_Rm_in = 32'h1234_5678; dest_in = 4'h1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (we_n_o[0] !== 1'b1 || oe_o[0] !== 1'b0 || addr_o[0] !== 18'h0) begin
            errors++;
            $display("FAIL reset_bus: we_n=%b oe=%b addr=%h, want 1 0 0", we_n_o[0], oe_o[0], addr_o[0]);
        end
        checks++;
        if (mdo_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mdo: got %h want 0", mdo_o[0]);
        end
        rst_n[0] = 1'b1;
        #1;
        checks++;
        if (ready_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 0", ready_o[0]);
        end
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (ready_o[0] !== 1'b1 && n < 50);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL reset_first_txn: ready rose after %0d cycles, want 5", n);
        end
        ref_mem[int'(word_of(alu_res_in))] = val_Rm_in;
    endtask

    task automatic test_alu(input logic wb, input logic [31:0] res, input logic [3:0] dst);
        @(negedge clk);
        wb_en_in = wb; mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
        alu_res_in = res; val_Rm_in = $urandom; dest_in = dst;
        #1;
        checks++;
        if (ready_o[sel] !== 1'b1 || wb_out_o[sel] !== wb || rd_out_o[sel] !== 1'b0) begin
            errors++;
            $display("FAIL alu_ctrl: ready=%b wb=%b rd=%b, want 1 %b 0", ready_o[sel], wb_out_o[sel], rd_out_o[sel], wb);
        end
        checks++;
        if (alu_out_o[sel] !== res || dest_out_o[sel] !== dst) begin
            errors++;
            $display("FAIL alu_pass: alu=%h dest=%h, want %h %h", alu_out_o[sel], dest_out_o[sel], res, dst);
        end
        checks++;
        if (we_n_o[sel] !== 1'b1 || oe_o[sel] !== 1'b0 || addr_o[sel] !== 18'h0 || mdo_o[sel] !== exp_mdo[sel]) begin
            errors++;
            $display("FAIL alu_idle: we_n=%b oe=%b addr=%h mdo=%h, want 1 0 0 %h", we_n_o[sel], oe_o[sel], addr_o[sel], mdo_o[sel], exp_mdo[sel]);
        end
    endtask

    task automatic test_store_load();
        sel = 0;
        run_txn(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF);
        checks++;
        if (sram_rd(18'd2) !== 16'hBEEF || sram_rd(18'd3) !== 16'hDEAD) begin
            errors++;
            $display("FAIL store_halves: sram[2]=%h sram[3]=%h, want BEEF DEAD", sram_rd(18'd2), sram_rd(18'd3));
        end
        run_txn(1'b0, 1'b1, 32'd1028, 32'h0);
        // Wrap-around below BASE maps to the top word.
        run_txn(1'b1, 1'b0, 32'(BASE) - 32'd4, 32'hCAFE_F00D);
        run_txn(1'b0, 1'b1, 32'(BASE) - 32'd4, 32'h0);
        run_txn(1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D);
        run_txn(1'b0, 1'b1, 32'd1032, 32'h0);
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] a;
        logic [16:0] w;
        int c0;
        sel = 0;
        a = 32'(BASE) + 32'd8;
        w = word_of(a);
        run_txn(1'b1, 1'b0, a, 32'hAAAA_5555);
        run_txn(1'b0, 1'b1, 32'd1028, 32'h0);
        c0 = commits;
        @(negedge clk);
        wb_en_in = 1'b0; mem_read_en_in = 1'b0; mem_write_en_in = 1'b1;
        alu_res_in = a; val_Rm_in = 32'h1234_9876;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (we_n_o[0] !== 1'b0 || addr_o[0] !== {w, 1'b1}) begin
            errors++;
            $display("FAIL mid_hi_phase: we_n=%b addr=%h, want 0 %h", we_n_o[0], addr_o[0], {w, 1'b1});
        end
        rst_n[0] = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (we_n_o[0] !== 1'b1 || oe_o[0] !== 1'b0 || addr_o[0] !== 18'h0 || mdo_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_state: we_n=%b oe=%b addr=%h mdo=%h, want 1 0 0 0", we_n_o[0], oe_o[0], addr_o[0], mdo_o[0]);
        end
        exp_mdo[0] = 32'h0;
        set_idle();
        rst_n[0] = 1'b1;
        #1;
        checks++;
        if (ready_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_idle_ready: got %b want 1", ready_o[0]);
        end
        checks++;
        if (commits - c0 != 1) begin
            errors++;
            $display("FAIL mid_reset_commits: got %0d halfword writes, want 1", commits - c0);
        end
        ref_mem[int'(w)] = {ref_rd(w)[31:16], 16'h9876};
        run_txn(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic test_random();
        int op;
        logic [31:0] a;
        sel = 0;
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 3);
            a = 32'(BASE) + 32'(4 * $urandom_range(0, 7));
            case (op)
                0: test_alu(1'($urandom), $urandom, 4'($urandom));
                1: run_txn(1'b0, 1'b1, a, 32'h0);
                2: run_txn(1'b1, 1'b0, a, $urandom);
                default: run_txn(1'b1, 1'b1, a, $urandom);
            endcase
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        @(negedge clk);
        set_idle();
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b1;
        @(negedge clk);
        sel = 1;
        run_txn(1'b0, 1'b1, 32'd1028, 32'h0);
        run_txn(1'b1, 1'b0, 32'd1036, 32'h5A5A_C3C3);
        run_txn(1'b0, 1'b1, 32'd1036, 32'h0);
        c0 = commits;
        @(negedge clk);
        set_idle();
        repeat (4) @(negedge clk);
        checks++;
        if (commits != c0) begin
            errors++;
            $display("FAIL no_duplicate_write: %0d extra halfword writes after completion", commits - c0);
        end
        test_alu(1'b1, 32'h0000_0042, 4'h5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        exp_mdo[0] = 32'h0;
        exp_mdo[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            prev_we_low[k] = 1'b0;
            prev_addr[k]   = 18'h0;
            prev_dat[k]    = 16'h0;
            dq_in_o[k]     = 16'h0;
        end
        wb_en_in = 1'b0; mem_read_en_in = 1'b0; mem_write_en_in = 1'b0;
        alu_res_in = 32'h0; val_Rm_in = 32'h0; dest_in = 4'h0;

        test_reset();
        test_alu(1'b1, 32'h0000_0042, 4'h3);
        test_store_load();
        test_reset_mid_write();
        test_random();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
